// File: rtl/branch_ctrl.sv
// Branch resolution and 2-bit BHT prediction for the RV32I pipeline.
// Resolves EX-stage branches, redirects fetch on a mispredict and squashes the wrong-path IF/ID stages.
module branch_ctrl #(
    parameter int BHT_DEPTH    = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [31:0]      if_pc_i,
    input  logic             if_is_br_i,
    output logic             if_pred_taken_o,
    input  logic             ex_valid_i,
    input  logic             ex_is_br_i,
    input  logic [2:0]       ex_funct3_i,
    input  logic [31:0]      ex_pc_i,
    input  logic [31:0]      ex_target_i,
    input  logic             ex_pred_taken_i,
    input  logic             br_less_i,
    input  logic             br_equal_i,
    output logic             br_unsigned_o,
    output logic             ex_taken_o,
    output logic             mispredict_o,
    output logic [31:0]      redirect_pc_o,
    output logic             flush_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    state_t          state_q, state_d;
    logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [1:0]      bht_q [BHT_DEPTH];
    logic            rv;
    logic            cond_taken;
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic            unused_pc_bits;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        res = cnt;
        if (taken && cnt != 2'b11) begin
            res = cnt + 2'b01;
        end else if (!taken && cnt != 2'b00) begin
            res = cnt - 2'b01;
        end
        return res;
    endfunction

    // Unsigned select goes out combinationally so the comparator flags settle this cycle.
    assign br_unsigned_o = ex_funct3_i[1];

    always_comb begin
        cond_taken = 1'b0;
        case (ex_funct3_i)
            3'b000:  cond_taken = br_equal_i;
            3'b001:  cond_taken = !br_equal_i;
            3'b100:  cond_taken = br_less_i;
            3'b101:  cond_taken = !br_less_i;
            3'b110:  cond_taken = br_less_i;
            3'b111:  cond_taken = !br_less_i;
            default: cond_taken = 1'b0;
        endcase
    end

    // EX holds wrong-path instructions while the flush counter is running.
    assign rv            = ex_valid_i & ex_is_br_i & (flush_cnt_q == '0);
    assign ex_taken_o    = rv & cond_taken;
    assign mispredict_o  = rv & (ex_taken_o != ex_pred_taken_i);
    assign redirect_pc_o = !mispredict_o ? 32'd0 :
                           ex_taken_o    ? ex_target_i : ex_pc_i + 32'd4;

    assign if_idx          = if_pc_i[IDX_W+1:2];
    assign ex_idx          = ex_pc_i[IDX_W+1:2];
    assign if_pred_taken_o = if_is_br_i & bht_q[if_idx][1];
    assign unused_pc_bits  = ^{if_pc_i[31:IDX_W+2], if_pc_i[1:0]};

    // No bypass: a fetch read of the entry being updated sees the old counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (rv) begin
            bht_q[ex_idx] <= sat_update(bht_q[ex_idx], ex_taken_o);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            IDLE: begin
                if (mispredict_o) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FC_W'(FLUSH_CYCLES);
                end
            end
            FLUSH: begin
                flush_cnt_d = flush_cnt_q - FC_W'(1);
                if (flush_cnt_q == FC_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                flush_cnt_d = '0;
            end
        endcase
    end

    assign flush_o = (state_q == FLUSH);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            br_cnt_o      <= '0;
            mispred_cnt_o <= '0;
        end else begin
            if (rv) begin
                br_cnt_o <= br_cnt_o + CNT_W'(1);
            end
            if (mispredict_o) begin
                mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Randomized and directed bench for branch_ctrl against an operand-level reference model.
module tb_branch_ctrl;

    localparam int BHT_DEPTH    = 16;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 32;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic [31:0]      if_pc_i;
    logic             if_is_br_i;
    logic             if_pred_taken_o;
    logic             ex_valid_i;
    logic             ex_is_br_i;
    logic [2:0]       ex_funct3_i;
    logic [31:0]      ex_pc_i;
    logic [31:0]      ex_target_i;
    logic             ex_pred_taken_i;
    logic             br_less_i;
    logic             br_equal_i;
    logic             br_unsigned_o;
    logic             ex_taken_o;
    logic             mispredict_o;
    logic [31:0]      redirect_pc_o;
    logic             flush_o;
    logic [CNT_W-1:0] br_cnt_o;
    logic [CNT_W-1:0] mispred_cnt_o;

    branch_ctrl #(
        .BHT_DEPTH   (BHT_DEPTH),
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .if_pc_i        (if_pc_i),
        .if_is_br_i     (if_is_br_i),
        .if_pred_taken_o(if_pred_taken_o),
        .ex_valid_i     (ex_valid_i),
        .ex_is_br_i     (ex_is_br_i),
        .ex_funct3_i    (ex_funct3_i),
        .ex_pc_i        (ex_pc_i),
        .ex_target_i    (ex_target_i),
        .ex_pred_taken_i(ex_pred_taken_i),
        .br_less_i      (br_less_i),
        .br_equal_i     (br_equal_i),
        .br_unsigned_o  (br_unsigned_o),
        .ex_taken_o     (ex_taken_o),
        .mispredict_o   (mispredict_o),
        .redirect_pc_o  (redirect_pc_o),
        .flush_o        (flush_o),
        .br_cnt_o       (br_cnt_o),
        .mispred_cnt_o  (mispred_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_chk = 0;
    int          n_err = 0;
    int          bht_m [BHT_DEPTH];
    int          flush_left;
    logic [31:0] br_m, mis_m;
    logic [31:0] rs1, rs2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Branch semantics straight from the ISA, on the real operand values.
    function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % BHT_DEPTH);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < BHT_DEPTH; i++) bht_m[i] = 1;
        flush_left = 0;
        br_m       = 0;
        mis_m      = 0;
    endtask

    // Called just after a rising edge; checks at the falling edge, then advances the model.
    task automatic step();
        bit          rv, tk, mp;
        logic [31:0] rd;
        int          ei;
        br_less_i  = ex_funct3_i[1] ? (rs1 < rs2) : ($signed(rs1) < $signed(rs2));
        br_equal_i = (rs1 == rs2);
        @(negedge clk_i);
        rv = ex_valid_i && ex_is_br_i && (flush_left == 0);
        tk = rv && ref_taken(ex_funct3_i, rs1, rs2);
        mp = rv && (tk != ex_pred_taken_i);
        rd = mp ? (tk ? ex_target_i : ex_pc_i + 32'd4) : 32'd0;
        chk("unsigned_sel", 32'(br_unsigned_o), 32'(ex_funct3_i == 3'b110 || ex_funct3_i == 3'b111 ||
                                                   ex_funct3_i == 3'b010 || ex_funct3_i == 3'b011));
        chk("taken", 32'(ex_taken_o), 32'(tk));
        chk("mispredict", 32'(mispredict_o), 32'(mp));
        chk("redirect", redirect_pc_o, rd);
        chk("if_pred", 32'(if_pred_taken_o), 32'(if_is_br_i && bht_m[idx_of(if_pc_i)] >= 2));
        chk("flush", 32'(flush_o), 32'(flush_left > 0));
        chk("br_cnt", br_cnt_o, br_m);
        chk("mispred_cnt", mispred_cnt_o, mis_m);
        @(posedge clk_i);
        if (rst_ni) begin
            if (flush_left > 0) flush_left--;
            if (rv) begin
                ei = idx_of(ex_pc_i);
                bht_m[ei] = tk ? ((bht_m[ei] < 3) ? bht_m[ei] + 1 : 3)
                               : ((bht_m[ei] > 0) ? bht_m[ei] - 1 : 0);
                br_m++;
            end
            if (mp) begin
                mis_m++;
                flush_left = FLUSH_CYCLES;
            end
        end
        #1;
    endtask

    task automatic set_br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                          input logic [31:0] a, input logic [31:0] b, input logic pred);
        ex_valid_i      = 1'b1;
        ex_is_br_i      = 1'b1;
        ex_funct3_i     = f3;
        ex_pc_i         = pc;
        ex_target_i     = tgt;
        ex_pred_taken_i = pred;
        rs1             = a;
        rs2             = b;
    endtask

    task automatic set_idle();
        ex_valid_i      = 1'b0;
        ex_is_br_i      = 1'b0;
        ex_funct3_i     = 3'b000;
        ex_pc_i         = 32'd0;
        ex_target_i     = 32'd0;
        ex_pred_taken_i = 1'b0;
        rs1             = 32'd0;
        rs2             = 32'd0;
        if_pc_i         = 32'd0;
        if_is_br_i      = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] rand_pc();
        case ($urandom_range(0, 9))
            0:       return $urandom & 32'hFFFF_FFFC;
            1:       return 32'hFFFF_FFFC;
            default: return 32'h100 + {25'd0, 5'($urandom_range(0, 31)), 2'b00};
        endcase
    endfunction

    task automatic rand_ops();
        case ($urandom_range(0, 3))
            0: begin rs1 = $urandom; rs2 = rs1; end
            1: begin rs1 = $urandom; rs2 = $urandom; end
            2: begin rs1 = 32'($urandom_range(0, 3)); rs2 = 32'($urandom_range(0, 3)); end
            default: begin rs1 = $urandom; rs2 = rs1 ^ 32'h8000_0000; end
        endcase
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0;
        set_idle();
        br_less_i  = 1'b0;
        br_equal_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_flush", 32'(flush_o), 32'd0);
        chk("rst_br_cnt", br_cnt_o, 32'd0);
        chk("rst_mis_cnt", mispred_cnt_o, 32'd0);
        chk("rst_redirect", redirect_pc_o, 32'd0);
        chk("rst_taken", 32'(ex_taken_o), 32'd0);
        release_reset();

        // BEQ taken against a not-taken prediction
        set_br(3'b000, 32'h100, 32'h80, 32'd5, 32'd5, 1'b0);
        step();
        set_idle();
        if_pc_i    = 32'h100;
        if_is_br_i = 1'b1;
        repeat (3) step();

        // BLTU taken, then BLT not taken, on 1 vs 0xFFFFFFFF
        set_br(3'b110, 32'h200, 32'h300, 32'd1, 32'hFFFF_FFFF, 1'b1);
        step();
        set_br(3'b100, 32'h204, 32'h300, 32'd1, 32'hFFFF_FFFF, 1'b0);
        step();

        // Same branch trained taken until the counter saturates
        for (int i = 0; i < 4; i++) begin
            set_br(3'b000, 32'h104, 32'h40, 32'd9, 32'd9, 1'b1);
            if_pc_i    = 32'h104;
            if_is_br_i = 1'b1;
            step();
        end
        set_idle();
        if_pc_i    = 32'h104;
        if_is_br_i = 1'b1;
        step();
        if_is_br_i = 1'b0;
        step();

        // Valid branches in EX during the flush window are ignored
        set_br(3'b001, 32'h300, 32'h500, 32'd3, 32'd3, 1'b1);
        step();
        for (int i = 0; i < FLUSH_CYCLES; i++) begin
            set_br(3'b000, 32'h308 + 32'(i * 4), 32'h10, 32'd1, 32'd1, 1'b0);
            step();
        end
        set_idle();
        repeat (3) step();

        // Not-taken fall-through wraps past the top of the address space
        set_br(3'b001, 32'hFFFF_FFFC, 32'h1234, 32'd7, 32'd7, 1'b1);
        step();
        set_idle();
        repeat (3) step();

        // Mispredict presented while reset is held: reset wins
        rst_ni = 1'b0;
        model_reset();
        set_br(3'b000, 32'h100, 32'h80, 32'd2, 32'd2, 1'b0);
        step();
        set_idle();
        release_reset();
        step();

        // Reset asserted in the middle of a flush
        set_br(3'b000, 32'h140, 32'h80, 32'd4, 32'd4, 1'b0);
        step();
        set_idle();
        #2;
        rst_ni = 1'b0;
        #1;
        chk("midflush_flush", 32'(flush_o), 32'd0);
        chk("midflush_br_cnt", br_cnt_o, 32'd0);
        chk("midflush_mis_cnt", mispred_cnt_o, 32'd0);
        model_reset();
        if_is_br_i = 1'b1;
        for (int i = 0; i < BHT_DEPTH; i++) begin
            if_pc_i = 32'(i) << 2;
            #1;
            chk("midflush_bht_pred", 32'(if_pred_taken_o), 32'd0);
        end
        set_idle();
        release_reset();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            ex_valid_i      = ($urandom_range(0, 9) < 8);
            ex_is_br_i      = ($urandom_range(0, 9) < 7);
            ex_funct3_i     = 3'($urandom_range(0, 7));
            ex_pc_i         = rand_pc();
            ex_target_i     = $urandom & 32'hFFFF_FFFE;
            ex_pred_taken_i = 1'($urandom_range(0, 1));
            if_pc_i         = rand_pc();
            if_is_br_i      = 1'($urandom_range(0, 1));
            rand_ops();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
